// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite memory slave with programmable wait states and an
// address error window.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,   AHB-Lite address phase and control inputs
//   HWRITE, HSIZE, HBURST,
//   HPROT, HREADY
//   HWDATA [DW]            write data (data phase)
//   HREADYOUT, HRESP       transfer done, 1 = ERROR response
//   HRDATA [DW]            read data; holds until the next read completes
//
// Address-phase controls are captured when a transfer is accepted. The
// registered controls drive the data phase. A write commits on the edge that
// ends its last data-phase cycle. A read loads HRDATA on the edge that starts
// its last data-phase cycle. HBURST and HPROT have no effect.
module ahb_mem_slave #(
  parameter int          DW        = 64,
  parameter int          DEPTH     = 1024,
  parameter int          WS_MODE   = 0,
  parameter int          WS_FIXED  = 0,
  parameter logic [3:0]  WS_MASK   = 4'hF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [31:0] ERR_BASE  = 32'hFFFF_0000,
  parameter logic [31:0] ERR_MASK  = 32'hFFFF_0000
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic [3:0]    HPROT,
  input  logic          HREADY,
  input  logic [DW-1:0] HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [DW-1:0] HRDATA
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]    r_state;
  logic          r_act;     // an OKAY data phase is pending or in progress
  logic          r_write;
  logic [IW-1:0] r_idx;
  logic [NB-1:0] r_strb;
  logic [3:0]    r_cnt;
  logic [15:0]   r_lfsr;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_rdy, w_acc, w_err, w_commit, w_ld_rd;
  logic [3:0]    w_ws;
  logic [IW-1:0] w_idx, w_rd_idx;
  logic [NB-1:0] w_strb;
  logic [DW-1:0] w_wmask, w_rd_data;
  logic [15:0]   w_lfsr_nxt;
  logic          w_unused;

  assign w_unused  = &{1'b0, HTRANS[0], HBURST, HPROT};

  assign w_rdy     = (r_state == S_IDLE) | (r_state == S_ERR2);
  assign HREADYOUT = w_rdy;
  assign HRESP     = (r_state == S_ERR1) | (r_state == S_ERR2);
  assign HRDATA    = r_rdata;

  // Acceptance is also gated by our own ready. A compliant master never
  // presents HREADY=1 during our wait states, but the FSM stays safe if it does.
  assign w_acc = HSEL & HREADY & HTRANS[1] & w_rdy;
  assign w_idx = HADDR[IW+LB-1:LB];
  assign w_err = ((HADDR & ERR_MASK) == ERR_BASE) | (HSIZE > 3'(LB));
  assign w_ws  = (WS_MODE == 1) ? (r_lfsr[3:0] & WS_MASK) : 4'(WS_FIXED);

  // Right-shifting Fibonacci form. Taps 16,14,13,11 are bits 0,2,3,5.
  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // A byte is strobed when it lies in the same naturally aligned 2^HSIZE
  // chunk as the address.
  always_comb begin
    w_strb = '0;
    for (int b = 0; b < NB; b++)
      if ((b >> HSIZE) == (int'(HADDR[LB-1:0]) >> HSIZE)) w_strb[b] = 1'b1;
  end

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < NB; b++) w_wmask[8*b +: 8] = {8{r_strb[b]}};
  end

  assign w_commit = (r_state == S_IDLE) & r_act & r_write;

  // Read data is loaded one edge before the final data-phase cycle. For ws=0
  // that edge is the accept edge, so a write finishing there is forwarded.
  assign w_ld_rd  = (w_acc & ~HWRITE & ~w_err & (w_ws == 4'd0)) |
                    ((r_state == S_WAIT) & (r_cnt == 4'd1) & ~r_write);
  assign w_rd_idx = (r_state == S_WAIT) ? r_idx : w_idx;

  always_comb begin
    w_rd_data = r_mem[w_rd_idx];
    if (w_commit && (r_idx == w_rd_idx))
      w_rd_data = (w_rd_data & ~w_wmask) | (HWDATA & w_wmask);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_act   <= 1'b0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_strb  <= '0;
      r_cnt   <= '0;
      r_lfsr  <= LFSR_SEED;
      r_rdata <= '0;
    end else begin
      if (w_ld_rd) r_rdata <= w_rd_data;
      if (w_acc)   r_lfsr  <= w_lfsr_nxt;
      case (r_state)
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_IDLE;
        end
        S_ERR1: r_state <= S_ERR2;
        default: begin
          // IDLE and ERR2 are ready cycles, so a new transfer may start here.
          r_act <= w_acc & ~w_err;
          if (w_acc) begin
            r_write <= HWRITE;
            r_idx   <= w_idx;
            r_strb  <= w_strb;
            r_cnt   <= w_ws;
            if (w_err)              r_state <= S_ERR1;
            else if (w_ws != 4'd0)  r_state <= S_WAIT;
            else                    r_state <= S_IDLE;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // The memory array is not reset. Its contents survive HRESETn, and r_act
  // drops asynchronously, so an aborted write never commits.
  always_ff @(posedge HCLK) begin
    if (w_commit)
      for (int b = 0; b < NB; b++)
        if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
module tb_ahb_mem_slave;
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [63:0] wdata;
  } txn_t;

  typedef struct {
    bit          err;
    bit          rd;
    logic [63:0] rdata;
    int          ws;
  } exp_t;

  localparam logic [31:0] EB    = 32'hFFFF_0000;
  localparam logic [31:0] EM    = 32'hFFFF_0000;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit done [3];

  task automatic chk(input bit ok, input string nm, input int c,
                     input logic [63:0] act, input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cfg%0d %s: got %h want %h", c, nm, act, req);
    end
  endtask

  // cfg0: DW=64 zero waits; cfg1: DW=32 LFSR waits; cfg2: DW=64 three waits
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int         DW  = (g == 1) ? 32 : 64;
    localparam int         WSM = (g == 1) ? 1 : 0;
    localparam int         WSF = (g == 2) ? 3 : 0;
    localparam logic [3:0] MSK = (g == 1) ? 4'h7 : 4'hF;
    localparam int         NB  = DW / 8;
    localparam int         LB  = $clog2(NB);
    localparam int         IW  = $clog2(DEPTH);

    logic          rst_n, hsel, hwrite, hready, hreadyout, hresp;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize, hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata, hrdata;

    assign hready = hreadyout;

    ahb_mem_slave #(
      .DW(DW), .DEPTH(DEPTH), .WS_MODE(WSM), .WS_FIXED(WSF), .WS_MASK(MSK),
      .LFSR_SEED(SEED), .ERR_BASE(EB), .ERR_MASK(EM)
    ) dut (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HPROT(hprot), .HREADY(hready), .HWDATA(hwdata),
      .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
    );

    txn_t          txq [$];
    exp_t          sbq [$];
    logic [DW-1:0] mdl [DEPTH];
    logic [15:0]   mlfsr;
    bit            mon_en = 0;
    bit            in_d   = 0;

    // Reference model: byte-addressed memory, error rule and LFSR sequence.
    task automatic model(input txn_t t, output exp_t e);
      int idx, off, n, fb;
      n     = 1 << t.size;
      e.err = ((t.addr & EM) == EB) || (n > NB);
      e.ws  = e.err ? 1 : ((WSM == 1) ? int'(mlfsr & 16'(MSK)) : WSF);
      fb    = int'((mlfsr ^ (mlfsr >> 2) ^ (mlfsr >> 3) ^ (mlfsr >> 5)) & 16'd1);
      mlfsr = (mlfsr >> 1) | 16'(fb << 15);
      idx   = int'(t.addr / NB) % DEPTH;
      off   = int'(t.addr % NB);
      off   = off - (off % n);
      if (!e.err && t.wr)
        for (int k = 0; k < n; k++)
          mdl[idx][8*(off+k) +: 8] = t.wdata[8*(off+k) +: 8];
      e.rd    = !t.wr;
      e.rdata = 64'(mdl[idx]);
    endtask

    task automatic mk(input logic [31:0] a, input bit w, input int sz, input logic [63:0] d);
      txn_t t;
      t.addr = a; t.wr = w; t.size = 3'(sz); t.wdata = d;
      txq.push_back(t);
    endtask

    // Pipelined master: new address phase on every ready edge, HWDATA
    // follows one phase later. During wait cycles the address controls carry
    // garbage, which the slave must ignore.
    task automatic run_q();
      bit   pr = 1, av = 0, dv = 0;
      txn_t at, dt;
      exp_t e;
      int   n;
      for (n = 0; n < 20000; n++) begin
        @(negedge clk);
        if (!av && txq.size() == 0 && sbq.size() == 0 && !in_d) break;
        if (pr) begin
          if (av) begin
            model(at, e);
            sbq.push_back(e);
            dt = at;
            dv = 1;
          end else dv = 0;
          if (dv) hwdata = dt.wdata[DW-1:0];
          if (txq.size() > 0 && $urandom_range(0, 3) != 0) begin
            at = txq.pop_front();
            av = 1;
          end else av = 0;
        end
        hburst = 3'($urandom_range(0, 7));
        hprot  = 4'($urandom_range(0, 15));
        if (hreadyout) begin
          hsel   = av ? 1'b1 : 1'($urandom_range(0, 1));
          htrans = av ? {1'b1, 1'($urandom_range(0, 1))}
                      : (hsel ? {1'b0, 1'($urandom_range(0, 1))} : 2'($urandom_range(0, 3)));
          haddr  = av ? at.addr : $urandom;
          hwrite = av ? at.wr : 1'($urandom_range(0, 1));
          hsize  = av ? at.size : 3'($urandom_range(0, 3));
        end else begin
          haddr  = $urandom;
          hwrite = 1'($urandom_range(0, 1));
          hsize  = 3'($urandom_range(0, 7));
        end
        pr = hreadyout;
      end
      chk(n < 20000, "drain", g, 64'(n), 64'd20000);
    endtask

    initial begin : mon
      exp_t        cur;
      bit          have = 0, rbad = 0;
      int          wc = 0;
      logic [63:0] last_rd = '0;
      forever begin
        @(negedge clk);
        #1;
        if (!mon_en) begin
          in_d = 0; have = 0; last_rd = '0;
        end else begin
          if (in_d) begin
            if (!have) begin
              if (sbq.size() == 0) begin
                chk(0, "sb_underflow", g, 64'd0, 64'd1);
                in_d = 0;
              end else begin
                cur = sbq.pop_front();
                have = 1; wc = 0; rbad = 0;
              end
            end
            if (have) begin
              if (hresp !== cur.err) rbad = 1;
              if (hreadyout !== 1'b1) wc++;
              else begin
                chk(wc == cur.ws, "waits", g, 64'(wc), 64'(cur.ws));
                chk(!rbad, "hresp", g, 64'(hresp), 64'(cur.err));
                if (cur.rd && !cur.err) begin
                  chk(64'(hrdata) === cur.rdata, "rdata", g, 64'(hrdata), cur.rdata);
                  last_rd = cur.rdata;
                end else begin
                  chk(64'(hrdata) === last_rd, "rdata_hold", g, 64'(hrdata), last_rd);
                end
                have = 0; in_d = 0;
              end
            end
          end else begin
            chk(hreadyout === 1'b1 && hresp === 1'b0, "idle_resp", g,
                {62'd0, hreadyout, hresp}, 64'd2);
          end
          if (hreadyout && hsel && htrans[1]) in_d = 1;
        end
      end
    end

    initial begin : drv
      logic [31:0] a;
      int          sz, off;
      logic [63:0] keep;
      hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hsize = 0;
      hburst = 0; hprot = 0; hwdata = '0; rst_n = 0;
      repeat (3) @(negedge clk);
      #1;
      chk(hreadyout === 1'b1 && hresp === 1'b0, "reset_flags", g,
          {62'd0, hreadyout, hresp}, 64'd2);
      chk(64'(hrdata) === 64'd0, "reset_rdata", g, 64'(hrdata), 64'd0);
      @(negedge clk);
      rst_n = 1; mlfsr = SEED; mon_en = 1;

      for (int i = 0; i < 16; i++) mk(32'(i * NB), 1, LB, {$urandom, $urandom});
      mk(32'h100, 1, LB, {$urandom, $urandom});
      mk(32'h200, 1, LB, {$urandom, $urandom});
      // full-word write then read back; read with waits
      mk(32'h100, 1, 3, 64'h1122334455667788);
      mk(32'h100, 0, 3, 64'd0);
      mk(32'h200, 1, 3, 64'hCAFE_F00D_1234_5678);
      mk(32'h200, 0, 3, 64'd0);
      // halfword lane merge
      mk(32'h100, 1, 3, 64'd0);
      mk(32'h102, 1, 1, 64'hBEEF_BEEF_BEEF_BEEF);
      mk(32'h100, 0, 3, 64'd0);
      mk(32'h100, 0, 2, 64'd0);
      // error window: write then read both error
      mk(EB + 32'd4, 1, 2, 64'h0000_DEAD_0000_DEAD);
      mk(EB + 32'd4, 0, 2, 64'd0);
      // aliasing modulo DEPTH
      mk(32'h2000, 1, LB, 64'h0BAD_F00D_5555_AAAA);
      mk(32'h0, 0, LB, 64'd0);
      // back-to-back write/read to the same word
      mk(32'h18, 1, 0, 64'hA5A5_A5A5_A5A5_A5A5);
      mk(32'h18, 0, LB, 64'd0);
      for (int i = 0; i < 16; i++) mk(32'h100, 0, LB, 64'd0);
      for (int i = 0; i < 150; i++) begin
        sz  = $urandom_range(0, 3);
        off = $urandom_range(0, NB - 1) & ~((1 << sz) - 1);
        if ($urandom_range(0, 9) == 0)
          a = EB | ($urandom & 32'h0000_FFF0) | 32'(off);
        else
          a = 32'($urandom_range(0, 255) << (IW + LB)) | 32'($urandom_range(0, 15) * NB) | 32'(off);
        mk(a, 1'($urandom_range(0, 1)), sz, {$urandom, $urandom});
      end
      run_q();

      // Reset pulsed in the data phase of a write: the write must not land.
      @(negedge clk);
      mon_en = 0; rst_n = 0;
      @(negedge clk);
      rst_n = 1; mlfsr = SEED;
      keep = 64'(mdl[(32'h100 / NB) % DEPTH]);
      @(negedge clk);
      hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h100; hsize = 3'(LB);
      @(negedge clk);
      hsel = 0; htrans = 2'b00; hwdata = ~keep[DW-1:0]; rst_n = 0;
      #1;
      chk(hreadyout === 1'b1, "rst_mid_ready", g, 64'(hreadyout), 64'd1);
      chk(hresp === 1'b0 && 64'(hrdata) === 64'd0, "rst_mid_out", g, 64'(hrdata), 64'd0);
      @(negedge clk);
      rst_n = 1; mon_en = 1;
      mk(32'h100, 0, LB, 64'd0);
      run_q();
      done[g] = 1;
    end
  end

  initial begin
    for (int c = 0; c < 90000; c++) begin
      @(posedge clk);
      if (done[0] && done[1] && done[2]) break;
    end
    chk(done[0] && done[1] && done[2], "finish", 0,
        {61'd0, done[2], done[1], done[0]}, 64'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 The block SHALL have parameter DW, default 64, meaning AHB data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the memory depth in DW-wide words; DEPTH is a power of 2.
REQ-003 The block SHALL have parameter WS_MODE, default 0, where 0 selects fixed wait states and 1 selects LFSR pseudo-random wait states.
REQ-004 The block SHALL have parameter WS_FIXED, default 0, meaning the wait-state count used when WS_MODE=0 (range 0..15).
REQ-005 The block SHALL have parameter WS_MASK, default 4'hF, meaning the AND-mask applied to the LFSR output when WS_MODE=1.
REQ-006 The block SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR reset value; it SHALL be nonzero.
REQ-007 The block SHALL have parameters ERR_BASE (default 32'hFFFF_0000) and ERR_MASK (default 32'hFFFF_0000); an address addr is in the error window when (addr & ERR_MASK) == ERR_BASE.
REQ-008 HCLK  in  1  clock; the reset is HRESETn, asynchronous, active-low, and the clock is HCLK.
REQ-009 HRESETn  in  1  asynchronous active-low reset.
REQ-010 HSEL  in  1; HADDR  in  32; HTRANS  in  2; HWRITE  in  1; HSIZE  in  3; HBURST  in  3; HPROT  in  4; HREADY  in  1 -- standard AHB-Lite address-phase and control inputs.
REQ-011 HWDATA  in  DW  write data.
REQ-012 HREADYOUT  out  1; HRESP  out  1 (1=ERROR); HRDATA  out  DW.

Function
REQ-013 A transfer SHALL be accepted on a rising HCLK edge when HSEL & HREADY & HTRANS[1] are all 1 (NONSEQ or SEQ).
REQ-014 IDLE and BUSY transfers, or cycles with HSEL=0, SHALL produce a zero-wait OKAY response and SHALL NOT access memory.
REQ-015 The word index SHALL be HADDR[log2(DEPTH)+log2(DW/8)-1 : log2(DW/8)]; higher address bits SHALL be ignored, so accesses wrap modulo DEPTH.
REQ-016 The byte strobe SHALL be derived from HSIZE and the low HADDR bits as a naturally aligned 1/2/4/8-byte lane set within DW.
REQ-017 An accepted transfer SHALL be classed as an error if its address is in the error window, or if HSIZE > log2(DW/8).
REQ-018 The state machine SHALL have the states IDLE, WAIT, ERR1 and ERR2.
REQ-019 On an accepted OKAY transfer with wait count ws=0, the state SHALL stay IDLE and the data phase SHALL complete in the next cycle with HREADYOUT=1.
REQ-020 On an accepted OKAY transfer with ws>0, the state SHALL be WAIT, with HREADYOUT=0 for exactly ws cycles followed by one cycle of HREADYOUT=1.
REQ-021 On an accepted error transfer, the state SHALL be ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE.
REQ-022 An error transfer SHALL ignore its wait count and SHALL NOT modify memory.
REQ-023 ws SHALL be WS_FIXED when WS_MODE=0, and (lfsr[3:0] & WS_MASK) when WS_MODE=1.
REQ-024 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance exactly once per accepted transfer.
REQ-025 A write SHALL commit the strobed bytes of HWDATA on the final data-phase cycle (the edge where HREADYOUT=1); unstrobed bytes SHALL be unchanged.
REQ-026 Read data SHALL be presented on HRDATA during the final data-phase cycle and SHALL hold its value until the next read completes.
REQ-027 For a write followed back-to-back by a read to the same word, the read SHALL return the newly written data.
REQ-028 Address-phase signals SHALL be registered at acceptance; changes on HADDR, HWRITE or HSIZE during wait states SHALL NOT affect the transfer in progress.
REQ-029 HRESP SHALL be 0 in every cycle except ERR1 and ERR2.
REQ-030 HBURST and HPROT SHALL be accepted but SHALL NOT change the behaviour of the block.

Reset
REQ-031 While HRESETn=0, the outputs SHALL be HREADYOUT=1, HRESP=0 and HRDATA=0, the state SHALL be IDLE, and the LFSR SHALL hold LFSR_SEED.
REQ-032 Reset asserted mid-transfer SHALL abort that transfer with no memory write; memory contents SHALL be retained across reset and are not cleared.

Verification
REQ-033 DW=64, WS_FIXED=0: write 8 bytes 0x1122334455667788 to 0x100, then read 0x100 -> HRDATA=0x1122334455667788 with HREADYOUT=1 on both data phases.
REQ-034 WS_FIXED=3: a read of 0x200 -> HREADYOUT low for exactly 3 cycles, then high with the data.
REQ-035 A halfword write of 0xBEEF to 0x102 over 0x0 -> a read of 0x100 returns 0x00000000BEEF0000.
REQ-036 A write of 0xDEAD to ERR_BASE+4 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), and the following read of ERR_BASE+4 also errors; with DW=32, an HSIZE=3 transfer errors.
REQ-037 DEPTH=1024, DW=64: a write to 0x2000 aliases 0x0 -> a read of 0x0 returns the written data.
REQ-038 WS_MODE=1: 16 reads -> the wait counts match the reference LFSR sequence from LFSR_SEED; HRESETn pulsed during WAIT -> HREADYOUT=1 immediately and the aborted write is absent.
